// File: rtl/id_ex_issue_if.sv
// Decode/issue stage bus: upstream instruction/regfile side and downstream ALU issue side.
// The master modport is the environment driving the stage; the slave modport is the stage itself.
interface id_ex_issue_if;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] op1_o;
  logic [31:0] op2_o;
  logic [2:0]  alu_op_o;
  logic [4:0]  shamt_o;
  logic        shdir_o;
  logic        sbtr_o;
  logic [4:0]  rd_o;
  logic        rd_we_o;
  logic        illegal_o;

  modport slave (
    input  flush_i, in_valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i, out_ready_i,
    output in_ready_o, rs1_addr_o, rs2_addr_o, out_valid_o, op1_o, op2_o, alu_op_o,
           shamt_o, shdir_o, sbtr_o, rd_o, rd_we_o, illegal_o
  );

  modport master (
    output flush_i, in_valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i, out_ready_i,
    input  in_ready_o, rs1_addr_o, rs2_addr_o, out_valid_o, op1_o, op2_o, alu_op_o,
           shamt_o, shdir_o, sbtr_o, rd_o, rd_we_o, illegal_o
  );
endinterface

// File: rtl/id_ex_issue.sv
// RV32I decode/issue stage for OP, OP-IMM, LUI and AUIPC: combinational decode captured into a
// main output register backed by a skid register, so in_ready never depends on out_ready.
module id_ex_issue #(
  parameter bit SUPPRESS_X0 = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  id_ex_issue_if.slave       bus,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  alu_op;
    logic [4:0]  shamt;
    logic        shdir;
    logic        sbtr;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } entry_t;

  entry_t     dec, m_q, s_q;
  state_t     state_q;
  logic       out_valid_q, in_ready_q, accept, legal, is_shift;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;

  assign opcode   = bus.instr_i[6:0];
  assign funct3   = bus.instr_i[14:12];
  assign funct7   = bus.instr_i[31:25];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign bus.rs1_addr_o = bus.instr_i[19:15];
  assign bus.rs2_addr_o = bus.instr_i[24:20];

  always_comb begin
    dec   = '0;
    legal = 1'b0;
    case (opcode)
      7'b0110011: begin
        legal = (funct7 == 7'b0000000) ||
                ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        dec.op1    = bus.rs1_data_i;
        dec.op2    = bus.rs2_data_i;
        dec.alu_op = funct3;
        dec.shamt  = is_shift ? bus.rs2_data_i[4:0] : 5'd0;
        dec.sbtr   = (funct3 == 3'b000) & bus.instr_i[30];
        dec.shdir  = (funct3 == 3'b101) & bus.instr_i[30];
      end
      7'b0010011: begin
        if (funct3 == 3'b001)      legal = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        else                       legal = 1'b1;
        dec.op1    = bus.rs1_data_i;
        dec.op2    = {{20{bus.instr_i[31]}}, bus.instr_i[31:20]};
        dec.alu_op = funct3;
        dec.shamt  = is_shift ? bus.instr_i[24:20] : 5'd0;
        dec.shdir  = (funct3 == 3'b101) & bus.instr_i[30];
      end
      7'b0110111: begin
        legal   = 1'b1;
        dec.op2 = {bus.instr_i[31:12], 12'b0};
      end
      7'b0010111: begin
        legal   = 1'b1;
        dec.op1 = bus.pc_i;
        dec.op2 = {bus.instr_i[31:12], 12'b0};
      end
      default: legal = 1'b0;
    endcase
    if (legal) begin
      dec.rd    = bus.instr_i[11:7];
      dec.rd_we = !(SUPPRESS_X0 && (bus.instr_i[11:7] == 5'd0));
    end else begin
      // Undecodable words still travel down the pipe, but carry nothing except the flag.
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits for ready, and data is held stable while valid=1 and ready=0.
  assign accept = bus.in_valid_i & in_ready_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= EMPTY;
      m_q         <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (bus.flush_i) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            m_q         <= dec;
            state_q     <= FULL;
            out_valid_q <= 1'b1;
          end
        end
        FULL: begin
          if (accept && bus.out_ready_i) begin
            m_q <= dec;
          end else if (accept) begin
            s_q        <= dec;
            state_q    <= SKID;
            in_ready_q <= 1'b0;
          end else if (bus.out_ready_i) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        SKID: begin
          if (bus.out_ready_i) begin
            m_q        <= s_q;
            state_q    <= FULL;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign state_o         = state_q;
  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.op1_o       = m_q.op1;
  assign bus.op2_o       = m_q.op2;
  assign bus.alu_op_o    = m_q.alu_op;
  assign bus.shamt_o     = m_q.shamt;
  assign bus.shdir_o     = m_q.shdir;
  assign bus.sbtr_o      = m_q.sbtr;
  assign bus.rd_o        = m_q.rd;
  assign bus.rd_we_o     = m_q.rd_we;
  assign bus.illegal_o   = m_q.illegal;

endmodule

// File: tb/tb_id_ex_issue.sv
// Bench for id_ex_issue: directed decode vectors, backpressure/flush/reset scenarios and a long
// random valid/ready run scored against an instruction-level decode model and an in-order queue.
module tb_id_ex_issue;
  localparam int W = 81;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         total;
  int         bad;
  logic [W-1:0] exp_q[$];

  id_ex_issue_if bus ();

  id_ex_issue #(.SUPPRESS_X0(1'b1)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave),
    .state_o(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction-level meaning of each word, packed as
  // {op1, op2, alu_op, shamt, shdir, sbtr, rd, rd_we, illegal}.
  function automatic logic [W-1:0] model(input logic [31:0] ins, input logic [31:0] pc,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [31:0] op1, op2;
    logic [2:0]  alu;
    logic [4:0]  sh;
    logic        sra, sub, ok;
    int unsigned opc, f3, f7;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    op1 = 0; op2 = 0; alu = 0; sh = 0; sra = 0; sub = 0; ok = 0;
    if (opc == 'h33) begin
      ok  = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
      op1 = a; op2 = b; alu = 3'(f3);
      if (f3 == 1 || f3 == 5) sh = b[4:0];
      sub = (f3 == 0) && (f7 == 'h20);
      sra = (f3 == 5) && (f7 == 'h20);
    end else if (opc == 'h13) begin
      ok  = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 'h20) : 1'b1;
      op1 = a; op2 = 32'($signed(ins[31:20])); alu = 3'(f3);
      if (f3 == 1 || f3 == 5) sh = ins[24:20];
      sra = (f3 == 5) && (f7 == 'h20);
    end else if (opc == 'h37) begin
      ok = 1; op2 = ins & 32'hFFFF_F000;
    end else if (opc == 'h17) begin
      ok = 1; op1 = pc; op2 = ins & 32'hFFFF_F000;
    end
    if (!ok) return {78'd0, 1'b0, 1'b0, 1'b1};
    return {op1, op2, alu, sh, sra, sub, ins[11:7], ins[11:7] != 5'd0, 1'b0};
  endfunction

  function automatic logic [W-1:0] observed();
    return {bus.op1_o, bus.op2_o, bus.alu_op_o, bus.shamt_o, bus.shdir_o, bus.sbtr_o,
            bus.rd_o, bus.rd_we_o, bus.illegal_o};
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, W'(bus.out_valid_o), W'(exp_q.size() > 0));
    check({tag, ".in_ready"}, W'(bus.in_ready_o), W'(exp_q.size() < 2));
    if (exp_q.size() > 0) check({tag, ".entry"}, observed(), exp_q[0]);
  endtask

  // driver: called at a negedge, drives one cycle, advances the model, returns at next negedge
  task automatic step(input string tag, input logic v, input logic [31:0] ins,
                      input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                      input logic ordy, input logic fl);
    logic [W-1:0] e;
    bit acc, pop;
    bus.in_valid_i  = v;
    bus.instr_i     = ins;
    bus.pc_i        = pc;
    bus.rs1_data_i  = a;
    bus.rs2_data_i  = b;
    bus.out_ready_i = ordy;
    bus.flush_i     = fl;
    e   = model(ins, pc, a, b);
    acc = v && (exp_q.size() < 2) && !fl;
    pop = (exp_q.size() > 0) && ordy && !fl;
    #1;
    check({tag, ".rs1_addr"}, W'(bus.rs1_addr_o), W'(ins[19:15]));
    check({tag, ".rs2_addr"}, W'(bus.rs2_addr_o), W'(ins[24:20]));
    @(posedge clk);
    if (fl) exp_q.delete();
    else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(e);
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int unsigned pick;
    r    = $urandom;
    pick = $urandom_range(0, 9);
    case (pick)
      0, 1, 2: begin
        r[6:0] = 7'h33;
        if ($urandom_range(0, 3) != 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      end
      3, 4, 5: begin
        r[6:0] = 7'h13;
        if ($urandom_range(0, 3) != 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      end
      6:       r[6:0] = 7'h37;
      7:       r[6:0] = 7'h17;
      default: begin end
    endcase
    if ($urandom_range(0, 15) == 0) r[11:7] = 5'd0;
    return r;
  endfunction

  task automatic idle_inputs();
    bus.in_valid_i = 0; bus.instr_i = 0; bus.pc_i = 0; bus.rs1_data_i = 0;
    bus.rs2_data_i = 0; bus.out_ready_i = 0; bus.flush_i = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.out_valid", W'(bus.out_valid_o), W'(0));
    check("rst.in_ready", W'(bus.in_ready_o), W'(1));
    check("rst.data", observed(), W'(0));
    check("rst.state", W'(state_dbg), W'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // directed decode vectors, consumer always ready
    step("add", 1, 32'h002081B3, 0, 5, 7, 1, 0);
    check("add.op1", W'(bus.op1_o), W'(5));
    check("add.op2", W'(bus.op2_o), W'(7));
    check("add.alu_op", W'(bus.alu_op_o), W'(0));
    check("add.sbtr", W'(bus.sbtr_o), W'(0));
    check("add.rd", W'(bus.rd_o), W'(3));
    check("add.rd_we", W'(bus.rd_we_o), W'(1));
    step("sub", 1, 32'h402081B3, 0, 5, 7, 1, 0);
    check("sub.sbtr", W'(bus.sbtr_o), W'(1));
    step("srai", 1, 32'h40435293, 0, 32'h1234, 0, 1, 0);
    check("srai.alu_op", W'(bus.alu_op_o), W'(5));
    check("srai.shamt", W'(bus.shamt_o), W'(4));
    check("srai.shdir", W'(bus.shdir_o), W'(1));
    check("srai.op2", W'(bus.op2_o), W'(32'h404));
    step("addi", 1, 32'hFFF00093, 0, 0, 0, 1, 0);
    check("addi.op2", W'(bus.op2_o), W'(32'hFFFF_FFFF));
    step("lui", 1, 32'h123450B7, 0, 9, 9, 1, 0);
    check("lui.op1", W'(bus.op1_o), W'(0));
    check("lui.op2", W'(bus.op2_o), W'(32'h1234_5000));
    step("auipc", 1, 32'h00001097, 32'h100, 0, 0, 1, 0);
    check("auipc.op1", W'(bus.op1_o), W'(32'h100));
    check("auipc.op2", W'(bus.op2_o), W'(32'h1000));
    step("add_x0", 1, 32'h00208033, 0, 1, 2, 1, 0);
    check("add_x0.rd_we", W'(bus.rd_we_o), W'(0));
    step("bad_f7", 1, 32'h02009093, 0, 3, 4, 1, 0);
    check("bad_f7.illegal", W'(bus.illegal_o), W'(1));
    check("bad_f7.rd_we", W'(bus.rd_we_o), W'(0));
    step("bad_opc", 1, 32'h0000007F, 0, 3, 4, 1, 0);
    check("bad_opc.illegal", W'(bus.illegal_o), W'(1));
    check("bad_opc.valid", W'(bus.out_valid_o), W'(1));
    step("drain", 0, 0, 0, 0, 0, 1, 0);

    // backpressure: third back-to-back word must be refused
    step("bp1", 1, 32'h00100093, 0, 0, 0, 0, 0);
    step("bp2", 1, 32'h00200113, 0, 0, 0, 0, 0);
    check("bp2.in_ready", W'(bus.in_ready_o), W'(0));
    step("bp3", 1, 32'h00300193, 0, 0, 0, 0, 0);
    check("bp3.rd_held", W'(bus.rd_o), W'(1));
    step("bp_rel1", 0, 0, 0, 0, 0, 1, 0);
    check("bp_rel1.rd", W'(bus.rd_o), W'(2));
    step("bp_rel2", 0, 0, 0, 0, 0, 1, 0);
    check("bp_rel2.valid", W'(bus.out_valid_o), W'(0));

    // flush while full with an incoming word
    step("fl1", 1, 32'h00100093, 0, 0, 0, 0, 0);
    step("fl2", 1, 32'h00200113, 0, 0, 0, 0, 0);
    step("fl3", 1, 32'h00300193, 0, 0, 0, 0, 1);
    check("flush.valid", W'(bus.out_valid_o), W'(0));
    check("flush.in_ready", W'(bus.in_ready_o), W'(1));
    step("fl4", 0, 0, 0, 0, 0, 1, 0);
    check("flush.nothing", W'(bus.out_valid_o), W'(0));

    // random valid/ready/flush traffic
    for (int i = 0; i < 10000; i++) begin
      step("rnd", ($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom, $urandom,
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 63) == 0));
    end

    // asynchronous reset between clock edges while holding two entries
    step("ar1", 1, 32'h00100093, 0, 0, 0, 0, 0);
    step("ar2", 1, 32'h00200113, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst.out_valid", W'(bus.out_valid_o), W'(0));
    check("arst.in_ready", W'(bus.in_ready_o), W'(1));
    check("arst.data", observed(), W'(0));
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 0, 0, 0, 0, 0, 1, 0);
    step("post_rst_add", 1, 32'h002081B3, 0, 11, 22, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
